// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: FSM states, error codes and the
// default start-of-frame marker.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StLen,
    StPayload,
    StCsum
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_out_stage.sv
// Single-entry valid/ready holding register for the payload stream. A new byte may be loaded
// in the same cycle the held one is accepted, giving full-rate back-to-back transfers.
module frame_out_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             drop_i,
  input  logic [Width-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             last_o,
  output logic             can_load_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (drop_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign can_load_o = ~valid_q | ready_i;
  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign last_o     = last_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Pops bytes from the UART RX FIFO, parses SOF/LEN/payload/XOR-checksum frames and streams the
// payload out. Define UART_FRAME_TIMEOUT_EN to abort frames after TIMEOUT_CYC idle cycles.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned         DATASIZE    = 8,
  parameter logic [DATASIZE-1:0] SOF_BYTE    = DATASIZE'(SOF_DEFAULT),
  parameter int unsigned         MAX_LEN     = 16,
  parameter int unsigned         TIMEOUT_CYC = 1024
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic                busy
);

  localparam int unsigned         CntW    = $clog2(MAX_LEN + 1);
  localparam logic [DATASIZE-1:0] MaxLenB = DATASIZE'(MAX_LEN);

  if (MAX_LEN < 1 || CntW > DATASIZE) begin : g_bad_max_len
    $error("MAX_LEN must be at least 1 and representable in DATASIZE bits");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATASIZE-1:0] csum_q, csum_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                frame_ok_q, frame_ok_d;
  logic                frame_err_q, frame_err_d;
  logic                can_load, load, load_last, drop;
  logic                tmo_hit;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);

  logic [TmoW-1:0] tmo_q, tmo_d;

  // Any cycle without a pop counts as idle, including output back-pressure stalls.
  assign tmo_hit = (state_q != StHunt) && !rinc && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q + TmoW'(1);
    if (state_q == StHunt || rinc || tmo_hit) tmo_d = '0;
  end

  always_ff @(posedge rclk) begin
    if (rrst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q     <= StHunt;
      cnt_q       <= '0;
      csum_q      <= '0;
      err_code_q  <= ERR_NONE;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      err_code_q  <= err_code_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    err_code_d  = err_code_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    load        = 1'b0;
    load_last   = 1'b0;
    drop        = 1'b0;
    if (tmo_hit) begin
      state_d     = StHunt;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      drop        = 1'b1;
    end else if (rinc) begin
      unique case (state_q)
        StHunt: begin
          if (rdata == SOF_BYTE) state_d = StLen;
        end
        StLen: begin
          if (rdata == '0 || rdata > MaxLenB) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = StHunt;
          end else begin
            cnt_d   = CntW'(rdata);
            csum_d  = rdata;
            state_d = StPayload;
          end
        end
        StPayload: begin
          load      = 1'b1;
          load_last = (cnt_q == CntW'(1));
          csum_d    = csum_q ^ rdata;
          cnt_d     = cnt_q - CntW'(1);
          if (load_last) state_d = StCsum;
        end
        StCsum: begin
          if (rdata == csum_q) begin
            frame_ok_d = 1'b1;
            err_code_d = ERR_NONE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
          state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // In PAYLOAD a pop is only allowed when the output register can take the byte.
  always_comb begin
    rinc = 1'b0;
    if (!rrst && !rempty) rinc = (state_q == StPayload) ? can_load : 1'b1;
  end

  assign busy      = (state_q != StHunt);
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

  frame_out_stage #(
    .Width(DATASIZE)
  ) u_out_stage (
    .clk_i     (rclk),
    .rst_i     (rrst),
    .load_i    (load),
    .drop_i    (drop),
    .data_i    (rdata),
    .last_i    (load_last),
    .ready_i   (out_ready),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .last_o    (out_last),
    .can_load_o(can_load)
  );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench: byte streams are parsed by a whole-stream reference parser that tags each
// byte with its role; per-cycle expectations are derived from those tags.
module tb_uart_frame_parser;
  import uart_frame_pkg::*;

  localparam int unsigned MaxLen     = 16;
  localparam int unsigned TimeoutCyc = 8;
  localparam int RoleDisc = 0, RoleSof = 1, RoleLen = 2, RolePay = 3, RoleCsum = 4;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic       rempty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       rinc;
  logic [7:0] out_data;
  logic       out_valid, out_last;
  logic       out_ready = 1'b1;
  logic       frame_ok, frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 rclk = ~rclk;

  uart_frame_parser #(
    .DATASIZE   (8),
    .SOF_BYTE   (8'hA5),
    .MAX_LEN    (MaxLen),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream under test and per-byte annotations from the reference parser.
  logic [7:0] s_byte[$];
  int         s_role[$];
  bit         s_last[$];
  int         s_evt[$];   // 0 none, 1 ok, 2 err
  logic [1:0] s_code[$];
  int         idx = 0;

  // Model of the visible outputs.
  bit         m_valid = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_last = 0;
  logic [1:0] m_code = ERR_NONE;
  int         m_pulse = 0;
  int         idle_run = 0;

  function automatic void push(input logic [7:0] b);
    s_byte.push_back(b);
  endfunction

  function automatic void clear_stream();
    s_byte.delete(); s_role.delete(); s_last.delete(); s_evt.delete(); s_code.delete();
    idx = 0;
  endfunction

  function automatic void add_frame(input int len, input bit corrupt);
    logic [7:0] sum, b;
    sum = len[7:0];
    push(8'hA5);
    push(len[7:0]);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      push(b);
      sum ^= b;
    end
    push(corrupt ? (sum ^ 8'($urandom_range(255, 1))) : sum);
  endfunction

  // Whole-stream parse straight from the framing rules; streams always end on a frame boundary.
  function automatic void parse_stream();
    int n, i, len;
    logic [7:0] sum;
    n = s_byte.size();
    s_role.delete(); s_last.delete(); s_evt.delete(); s_code.delete();
    for (int k = 0; k < n; k++) begin
      s_role.push_back(RoleDisc); s_last.push_back(0); s_evt.push_back(0);
      s_code.push_back(ERR_NONE);
    end
    i = 0;
    while (i < n) begin
      if (s_byte[i] != SOF_DEFAULT || i + 1 >= n) begin
        i++;
        continue;
      end
      s_role[i] = RoleSof;
      s_role[i+1] = RoleLen;
      len = int'(s_byte[i+1]);
      if (len == 0 || len > MaxLen) begin
        s_evt[i+1] = 2;
        s_code[i+1] = ERR_LEN;
        i += 2;
        continue;
      end
      sum = s_byte[i+1];
      for (int k = 0; k < len; k++) begin
        s_role[i+2+k] = RolePay;
        sum ^= s_byte[i+2+k];
      end
      s_last[i+1+len] = 1;
      s_role[i+2+len] = RoleCsum;
      if (s_byte[i+2+len] == sum) begin
        s_evt[i+2+len] = 1; s_code[i+2+len] = ERR_NONE;
      end else begin
        s_evt[i+2+len] = 2; s_code[i+2+len] = ERR_CSUM;
      end
      i += len + 3;
    end
  endfunction

  task automatic drive(input int rmode, input bit gaps_en);
    bit gap;
    gap = gaps_en && (idle_run < 3) && ($urandom_range(3) == 0);
    rempty = (idx >= s_byte.size()) || gap;
    rdata = rempty ? 8'($urandom) : s_byte[idx];
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = !out_ready;
      default: out_ready = (idle_run >= 3) ? 1'b1 : 1'($urandom_range(1));
    endcase
  endtask

  // One clock: check everything at the negedge, then advance the model over the posedge.
  task automatic step();
    bit exp_rinc, exp_busy, pop_seen, ready_seen, rst_seen;
    int r;
    @(negedge rclk);
    r = (idx < s_byte.size()) ? s_role[idx] : RoleDisc;
    exp_busy = (r == RoleLen) || (r == RolePay) || (r == RoleCsum);
    exp_rinc = !rrst && !rempty && (r != RolePay || !m_valid || out_ready);
    check_eq("rinc", rinc, exp_rinc);
    check_eq("busy", busy, exp_busy);
    check_eq("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check_eq("out_data", out_data, m_data);
      check_eq("out_last", out_last, m_last);
    end
    check_eq("frame_ok", frame_ok, m_pulse == 1);
    check_eq("frame_err", frame_err, m_pulse == 2);
    check_eq("err_code", err_code, m_code);
    pop_seen = rinc; ready_seen = out_ready; rst_seen = rrst;
    @(posedge rclk);
    #1;
    m_pulse = 0;
    if (rst_seen) begin
      m_valid = 0; m_data = 8'h00; m_last = 0; m_code = ERR_NONE;
      clear_stream();
    end else begin
      if (m_valid && ready_seen) m_valid = 0;
      if (pop_seen && idx < s_byte.size()) begin
        if (s_role[idx] == RolePay) begin
          m_valid = 1; m_data = s_byte[idx]; m_last = s_last[idx];
        end
        if (s_evt[idx] != 0) begin
          m_pulse = s_evt[idx]; m_code = s_code[idx];
        end
        idx++;
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
  endtask

  task automatic run_stream(input int rmode, input bit gaps_en, input string name);
    int cyc = 0;
    parse_stream();
    idx = 0;
    while ((idx < s_byte.size() || m_valid || m_pulse != 0) && cyc < 3000) begin
      drive(rmode, gaps_en);
      step();
      cyc++;
    end
    check_eq({name, "_pops"}, idx, s_byte.size());
    clear_stream();
  endtask

  task automatic build_random(input int items);
    int kind, n;
    logic [7:0] b;
    for (int k = 0; k < items; k++) begin
      kind = int'($urandom_range(9));
      if (kind <= 1) begin
        n = int'($urandom_range(3, 1));
        for (int j = 0; j < n; j++) begin
          b = 8'($urandom);
          push((b == 8'hA5) ? 8'h00 : b);
        end
      end else if (kind <= 6) begin
        add_frame(int'($urandom_range(MaxLen, 1)), 0);
      end else if (kind == 7) begin
        add_frame(int'($urandom_range(MaxLen, 1)), 1);
      end else if (kind == 8) begin
        push(8'hA5); push(8'($urandom_range(255, MaxLen + 1)));
      end else begin
        push(8'hA5); push(8'h00);
      end
    end
  endtask

`ifdef UART_FRAME_TIMEOUT_EN
  task automatic timeout_test();
    logic [7:0] seq [3];
    seq = '{8'hA5, 8'h04, 8'h01};
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rempty = 1'b0; rdata = seq[k];
      @(negedge rclk);
      check_eq("tmo_pop", rinc, 1'b1);
      @(posedge rclk); #1;
    end
    rempty = 1'b1; rdata = 8'hA5;
    for (int k = 1; k <= int'(TimeoutCyc); k++) begin
      @(negedge rclk);
      check_eq("tmo_early_err", frame_err, 1'b0);
      check_eq("tmo_wait_busy", busy, 1'b1);
      check_eq("tmo_held_valid", out_valid, 1'b1);
      @(posedge rclk); #1;
    end
    @(negedge rclk);
    check_eq("tmo_err", frame_err, 1'b1);
    check_eq("tmo_code", err_code, ERR_TIMEOUT);
    check_eq("tmo_busy", busy, 1'b0);
    check_eq("tmo_dropped", out_valid, 1'b0);
    @(posedge rclk); #1;
    @(negedge rclk);
    check_eq("tmo_err_pulse", frame_err, 1'b0);
    check_eq("tmo_code_held", err_code, ERR_TIMEOUT);
    @(posedge rclk); #1;
    m_code = ERR_TIMEOUT; m_valid = 0; m_pulse = 0;
    out_ready = 1'b1;
  endtask
`endif

  initial begin
    int cyc;
    // Reset with a pending SOF visible: nothing may be popped.
    rrst = 1'b1; rempty = 1'b0; rdata = 8'hA5; out_ready = 1'b1;
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    check_eq("rst_rinc", rinc, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 8'h00);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_frame_ok", frame_ok, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_err_code", err_code, ERR_NONE);
    check_eq("rst_busy", busy, 1'b0);
    @(posedge rclk); #1;
    rrst = 1'b0; rempty = 1'b1;

    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
    run_stream(0, 0, "good");

    push(8'h00); push(8'hFF); push(8'hA5); push(8'h01); push(8'h7E); push(8'h7F);
    run_stream(0, 0, "garbage");

    push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h00);
    push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h32);
    run_stream(0, 0, "bad_csum");

    add_frame(4, 0);
    run_stream(1, 0, "backpressure");

    build_random(60);
    run_stream(2, 1, "rand_ready");
    build_random(40);
    run_stream(1, 1, "rand_toggle");

    push(8'hA5); push(8'h00); push(8'hA5); push(8'h11);
    run_stream(0, 0, "bad_len");

    // Reset mid-payload with a byte stalled in the output register.
    push(8'hA5); push(8'h04); push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h00);
    parse_stream();
    idx = 0;
    cyc = 0;
    while (idx < 3 && cyc < 20) begin
      rempty = 1'b0; rdata = s_byte[idx]; out_ready = 1'b0;
      step();
      cyc++;
    end
    check_eq("rst_mid_pops", idx, 3);
    rrst = 1'b1; rempty = 1'b0; rdata = s_byte[idx];
    step();
    rrst = 1'b0; rempty = 1'b1; out_ready = 1'b1;
    step();
    check_eq("rst_mid_out_data", out_data, 8'h00);

`ifdef UART_FRAME_TIMEOUT_EN
    timeout_test();
`endif

    add_frame(5, 0);
    run_stream(2, 1, "recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Read-side consumer of the UART receive async FIFO, in the read clock domain.
- Pops bytes whenever the FIFO is not empty and parses framed packets: SOF, LEN, payload, XOR checksum.
- Streams payload bytes downstream over a valid/ready interface.
- Flags each frame as good or bad, with an error code.

Parameters:
- DATASIZE, 8, byte width of FIFO read data and of the output stream.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, largest legal LEN value. LEN range is 1..MAX_LEN.
- TIMEOUT_CYC, 1024, inter-byte timeout in rclk cycles. Used only with TIMEOUT_EN.

Ports:
- rclk  in  1  read-domain clock.
- rrst  in  1  synchronous, active-high reset.
- rempty  in  1  FIFO empty flag.
- rdata  in  DATASIZE  FIFO read data at the current read address. Combinational; valid whenever rempty=0.
- rinc  out  1  FIFO pop strobe (combinational).
- out_data  out  DATASIZE  payload byte.
- out_valid  out  1  out_data is valid.
- out_last  out  1  final payload byte of the frame.
- out_ready  in  1  downstream accepts the byte when out_valid & out_ready.
- frame_ok  out  1  one-cycle pulse: checksum matched.
- frame_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  cause of the error: 0 none, 1 bad LEN, 2 checksum mismatch, 3 timeout. Held until the next frame_ok or frame_err.
- busy  out  1  high when the state is not HUNT.

Behaviour:
- Reset values: state HUNT; out_valid, out_last, frame_ok, frame_err, err_code = 0; out_data = 0; count and checksum = 0. rinc is forced to 0 while rrst=1.
- Pop rule:
  - In HUNT, LEN and CSUM: rinc = ~rempty.
  - In PAYLOAD: rinc = ~rempty & (~out_valid | out_ready).
  - A byte is consumed exactly on cycles with rinc=1.
- State transitions (all on a popped byte):
  - HUNT: byte == SOF_BYTE -> LEN. Any other byte is discarded silently; stay in HUNT.
  - LEN: LEN = 0 or LEN > MAX_LEN -> frame_err, err_code=1, go to HUNT. Otherwise cnt = LEN, csum = LEN, go to PAYLOAD.
  - PAYLOAD: out_data = byte, out_valid = 1, out_last = (cnt==1), csum ^= byte, cnt -= 1. When cnt reaches 0 -> CSUM.
  - CSUM: byte == csum -> frame_ok, err_code=0. Otherwise frame_err, err_code=2. Go to HUNT in both cases.
  - A SOF_BYTE value inside LEN, PAYLOAD or CSUM is treated as data, not as a resync.
- Latency:
  - Byte popped in cycle N appears on out_data with out_valid=1 in cycle N+1.
  - frame_ok / frame_err assert in cycle N+1 after the CSUM byte is popped in cycle N.
- Output register:
  - out_valid clears on out_valid & out_ready when no new byte is loaded the same cycle.
  - Simultaneous accept and load gives back-to-back bytes at full rate.
  - out_data, out_last hold while out_valid & ~out_ready.
- Payload bytes are delivered before verification. The consumer must discard the frame on frame_err. frame_ok may assert while the last byte is still stalled in the output register.
- Synchronous reset mid-frame: return to HUNT next edge; drop the held byte; no frame_err pulse.
- cnt width: $clog2(MAX_LEN+1). csum width: DATASIZE.

Optional Feature:
- Macro UART_FRAME_TIMEOUT_EN.
- Defined:
  - A counter runs in LEN, PAYLOAD and CSUM. It increments on each cycle with no pop and clears on every pop and in HUNT.
  - On reaching TIMEOUT_CYC-1: frame_err, err_code=3, go to HUNT, drop any unsent payload byte (out_valid=0).
  - A stall caused by out_ready=0 also counts.
- Not defined: no counter; the parser waits indefinitely for the next byte.

Decomposition:
- Package uart_frame_pkg holds:
  - state enum (HUNT, LEN, PAYLOAD, CSUM);
  - error-code constants ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT;
  - default SOF value.
- One natural sub-module, frame_out_stage: the single-entry valid/ready holding register for out_data/out_last, with a load input and a can_load output.

Test Plan:
- Good frame: FIFO holds A5 03 11 22 33 03, out_ready=1.
  - out_data 11, 22, 33 on consecutive cycles; out_last with 33.
  - frame_ok pulse; err_code=0; six pops total.
- Garbage before SOF: 00 FF A5 01 7E 7F.
  - 00 and FF dropped; single byte 7E with out_last.
  - frame_ok (csum 01^7E=7F).
- Bad checksum: A5 02 10 20 00.
  - Bytes 10, 20 delivered.
  - frame_err, err_code=2; next frame parses cleanly.
- Bad LEN: A5 00, then A5 11 (17 > MAX_LEN).
  - frame_err with err_code=1 twice; no out_valid.
- Backpressure: good 4-byte frame, out_ready toggling 0/1 every cycle.
  - No byte lost or duplicated; rinc=0 whenever out_valid & ~out_ready in PAYLOAD.
- With UART_FRAME_TIMEOUT_EN, TIMEOUT_CYC=8: send A5 04 01, then hold rempty=1.
  - frame_err with err_code=3 after 8 idle cycles; busy=0.
  - Also assert rrst mid-payload: outputs return to reset values, no error pulse.
